ppm_multi_gen: RTL and testbench

//  Multi-channel pulse-position modulator; successor to the single-channel 8-bit PPM generator.
//  - One frame counter is shared by all channels. Each channel emits a PULSE_W-slot pulse at its programmed slot.
//  - Positions are loaded via valid/ready into a shadow bank. The shadow bank is committed atomically at the frame boundary.
//  - Sits between the tile input pins or register block and the uo_out pulse pins.

---
 rtl/ppm_pkg.sv | 10 +
 rtl/ppm_channel.sv | 45 ++++
 rtl/ppm_multi_gen.sv | 104 ++++++++++
 tb/tb_ppm_multi_gen.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/ppm_pkg.sv
// Shared constants and types for the multi-channel PPM generator.
package ppm_pkg;
  localparam int PPM_MAX_CHANNELS = 8;
  localparam int PPM_WIDTH        = 8;
  localparam int PPM_FRAME_LEN    = 256;
  localparam int PPM_PULSE_W      = 1;

  // One bit wider than a position so pos+PULSE_W never overflows.
  typedef logic [PPM_WIDTH:0] slot_t;
endpackage

// File: rtl/ppm_channel.sv
// One PPM output: active position register, pulse window comparator and
// registered pulse output.
module ppm_channel
  import ppm_pkg::*;
#(
  parameter int WIDTH     = PPM_WIDTH,
  parameter int FRAME_LEN = PPM_FRAME_LEN,
  parameter int PULSE_W   = PPM_PULSE_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_act_vld,
  input  logic             i_commit,
  input  logic [WIDTH-1:0] i_pos,
  input  logic [WIDTH-1:0] i_slot,
  output logic             o_pulse
);
  localparam logic [WIDTH:0] FL = (WIDTH+1)'(FRAME_LEN);
  localparam logic [WIDTH:0] PW = (WIDTH+1)'(PULSE_W);

  logic [WIDTH-1:0] r_pos;
  logic             r_pulse;
  logic [WIDTH:0]   w_slot, w_pos, w_end;
  logic             w_hit;

  always_ff @(posedge clk) begin
    if (rst)           r_pos <= '0;
    else if (i_commit) r_pos <= i_pos;
  end

  // Slot never exceeds FRAME_LEN-1, so the window clips at frame end by itself.
  assign w_slot = {1'b0, i_slot};
  assign w_pos  = {1'b0, r_pos};
  assign w_end  = w_pos + PW;
  assign w_hit  = i_en && i_act_vld && (w_pos < FL) &&
                  (w_slot >= w_pos) && (w_slot < w_end);

  always_ff @(posedge clk) begin
    if (rst) r_pulse <= 1'b0;
    else     r_pulse <= w_hit;
  end

  assign o_pulse = r_pulse;
endmodule

// File: rtl/ppm_multi_gen.sv
// Multi-channel PPM generator: shared slot counter, shadow bank with
// frame-boundary commit, sticky range error. Optional macro PPM_SYNC_EN
// enables the registered frame_sync marker.
module ppm_multi_gen
  import ppm_pkg::*;
#(
  parameter int CHANNELS  = 4,
  parameter int WIDTH     = PPM_WIDTH,
  parameter int FRAME_LEN = PPM_FRAME_LEN,
  parameter int PULSE_W   = PPM_PULSE_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [CHANNELS*WIDTH-1:0] s_pos,
  output logic [CHANNELS-1:0]       pulse_out,
  output logic                      frame_sync,
  output logic                      pos_err
);
  localparam logic [WIDTH:0] LAST = (WIDTH+1)'(FRAME_LEN - 1);
  localparam logic [WIDTH:0] FL   = (WIDTH+1)'(FRAME_LEN);

  logic [WIDTH-1:0]          r_slot;
  logic [CHANNELS*WIDTH-1:0] r_shadow;
  logic                      r_pending;
  logic                      r_act_vld;
  logic                      r_pos_err;

  logic                      w_bnd, w_xfer, w_commit, w_range;
  logic [CHANNELS*WIDTH-1:0] w_cpos;

  assign s_ready  = !r_pending;
  assign w_xfer   = s_valid && s_ready;
  assign w_bnd    = en && ({1'b0, r_slot} == LAST);
  // A transfer landing on the boundary cycle bypasses the shadow bank.
  assign w_commit = w_bnd && (r_pending || w_xfer);
  assign w_cpos   = r_pending ? r_shadow : s_pos;

  always_ff @(posedge clk) begin
    if (rst)        r_slot <= '0;
    else if (w_bnd) r_slot <= '0;
    else if (en)    r_slot <= r_slot + WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shadow  <= '0;
      r_pending <= 1'b0;
    end else if (w_commit) begin
      r_pending <= 1'b0;
    end else if (w_xfer) begin
      r_shadow  <= s_pos;
      r_pending <= 1'b1;
    end
  end

  always_comb begin
    w_range = 1'b0;
    for (int k = 0; k < CHANNELS; k++)
      if ({1'b0, w_cpos[k*WIDTH +: WIDTH]} >= FL) w_range = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_act_vld <= 1'b0;
      r_pos_err <= 1'b0;
    end else if (w_commit) begin
      r_act_vld <= 1'b1;
      r_pos_err <= r_pos_err | w_range;
    end
  end

  assign pos_err = r_pos_err;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    ppm_channel #(
      .WIDTH     (WIDTH),
      .FRAME_LEN (FRAME_LEN),
      .PULSE_W   (PULSE_W)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .i_en      (en),
      .i_act_vld (r_act_vld),
      .i_commit  (w_commit),
      .i_pos     (w_cpos[k*WIDTH +: WIDTH]),
      .i_slot    (r_slot),
      .o_pulse   (pulse_out[k])
    );
  end

`ifdef PPM_SYNC_EN
  logic r_sync;
  always_ff @(posedge clk) begin
    if (rst) r_sync <= 1'b0;
    else     r_sync <= en && (r_slot == '0);
  end
  assign frame_sync = r_sync;
`else
  assign frame_sync = 1'b0;
`endif
endmodule

// File: tb/tb_ppm_multi_gen.sv
// Directed bench for ppm_multi_gen: a 4ch/256/PW1 instance and a 2ch/200/PW4 instance.
module tb_ppm_multi_gen;
`ifdef PPM_SYNC_EN
  localparam int SYNC = 1;
`else
  localparam int SYNC = 0;
`endif

  logic        clk = 1'b0;
  logic        rst, en, s_valid, s_ready, frame_sync, pos_err;
  logic [31:0] s_pos;
  logic [3:0]  pulse_out;

  logic        b_en, b_valid, b_ready, b_sync, b_err;
  logic [15:0] b_pos;
  logic [1:0]  b_pulse;

  int n_cmp = 0;
  int n_err = 0;

  int a_first[4], a_cnt[4];
  int fs_first, fs_cnt, rdy_lo, pause_hi;
  int b_first[2], b_cnt[2];

  always #5 clk = ~clk;

  ppm_multi_gen #(.CHANNELS(4), .WIDTH(8), .FRAME_LEN(256), .PULSE_W(1)) u_a (
    .clk(clk), .rst(rst), .en(en), .s_valid(s_valid), .s_ready(s_ready),
    .s_pos(s_pos), .pulse_out(pulse_out), .frame_sync(frame_sync), .pos_err(pos_err)
  );

  ppm_multi_gen #(.CHANNELS(2), .WIDTH(8), .FRAME_LEN(200), .PULSE_W(4)) u_b (
    .clk(clk), .rst(rst), .en(b_en), .s_valid(b_valid), .s_ready(b_ready),
    .s_pos(b_pos), .pulse_out(b_pulse), .frame_sync(b_sync), .pos_err(b_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // Run n cycles of instance A, with en low for cycles p+1..p+l; record the
  // first cycle (1-based) each output is seen high and how often.
  task automatic obs_a(input int n, input int p, input int l);
    for (int k = 0; k < 4; k++) begin a_first[k] = 0; a_cnt[k] = 0; end
    fs_first = 0; fs_cnt = 0; rdy_lo = 0; pause_hi = 0;
    for (int j = 1; j <= n; j++) begin
      en = !(j > p && j <= p + l);
      step(1);
      s_valid = 1'b0;
      if (!en && (pulse_out != 4'd0 || frame_sync)) pause_hi++;
      for (int k = 0; k < 4; k++)
        if (pulse_out[k]) begin
          a_cnt[k]++;
          if (a_first[k] == 0) a_first[k] = j;
        end
      if (frame_sync) begin
        fs_cnt++;
        if (fs_first == 0) fs_first = j;
      end
      if (!s_ready) rdy_lo++;
    end
    en = 1'b1;
  endtask

  task automatic chk_a(input string tag, input int e0, input int e1, input int e2, input int e3);
    int e[4];
    e = '{e0, e1, e2, e3};
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s_first%0d", tag, k), a_first[k], e[k]);
      chk($sformatf("%s_cnt%0d", tag, k), a_cnt[k], 1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b0; s_valid = 1'b0; s_pos = '0;
    b_en = 1'b0; b_valid = 1'b0; b_pos = '0;
    step(2);
    rst = 1'b0;

    // Reset state and idle frames with no committed bank
    chk("rst_pulse", pulse_out, 0);
    chk("rst_ready", s_ready, 1);
    chk("rst_err",   pos_err, 0);
    chk("rst_sync",  frame_sync, 0);
    obs_a(512, 0, 0);
    chk("idle_pulses", a_cnt[0] + a_cnt[1] + a_cnt[2] + a_cnt[3], 0);
    chk("idle_sync_cnt", fs_cnt, 2 * SYNC);

    // Load {0,1,128,255} at slot 10
    step(10);
    s_valid = 1'b1; s_pos = {8'd255, 8'd128, 8'd1, 8'd0};
    chk("ld0_ready", s_ready, 1);
    step(1);
    s_valid = 1'b0;
    chk("ld0_pend", s_ready, 0);
    step(245);
    obs_a(256, 0, 0);
    chk_a("basic", 1, 2, 129, 256);
    chk("basic_sync_at", fs_first, SYNC ? 1 : 0);
    chk("basic_rdy_lo", rdy_lo, 0);

    // Second load stalls until the boundary
    step(5);
    s_valid = 1'b1; s_pos = {8'd103, 8'd102, 8'd101, 8'd100};
    chk("ld1_ready", s_ready, 1);
    step(1);
    s_pos = {8'd40, 8'd30, 8'd20, 8'd10};
    chk("ld1_pend", s_ready, 0);
    step(249);
    chk("stall_at_last", s_ready, 0);
    step(1);
    chk("free_after_bnd", s_ready, 1);
    obs_a(256, 0, 0);
    chk_a("l1", 101, 102, 103, 104);
    chk("l2_stall_len", rdy_lo, 255);
    obs_a(256, 0, 0);
    chk_a("l2", 11, 21, 31, 41);

    // Boundary-cycle load commits directly; then a 5-cycle en=0 pause
    step(255);
    s_valid = 1'b1; s_pos = {8'd200, 8'd70, 8'd60, 8'd50};
    chk("byp_ready_pre", s_ready, 1);
    step(1);
    s_valid = 1'b0;
    chk("byp_ready_post", s_ready, 1);
    obs_a(261, 51, 5);
    chk_a("pause", 51, 66, 76, 206);
    chk("pause_quiet", pause_hi, 0);
    chk("a_err", pos_err, 0);

    // Instance B: clip at frame end and out-of-range position
    en = 1'b0;
    b_en = 1'b1; b_valid = 1'b1; b_pos = {8'd210, 8'd198};
    chk("b_ready", b_ready, 1);
    step(1);
    b_valid = 1'b0;
    chk("b_pend", b_ready, 0);
    step(198);
    chk("b_err_pre", b_err, 0);
    step(1);
    chk("b_err_set", b_err, 1);
    for (int k = 0; k < 2; k++) begin b_first[k] = 0; b_cnt[k] = 0; end
    for (int j = 1; j <= 200; j++) begin
      step(1);
      for (int k = 0; k < 2; k++)
        if (b_pulse[k]) begin
          b_cnt[k]++;
          if (b_first[k] == 0) b_first[k] = j;
        end
    end
    chk("b_clip_first", b_first[0], 199);
    chk("b_clip_cnt", b_cnt[0], 2);
    chk("b_oor_cnt", b_cnt[1], 0);
    step(1);
    chk("b_no_wrap", b_pulse, 0);
    chk("b_err_sticky", b_err, 1);
    b_en = 1'b0;

    // Mid-frame reset drops pending and active banks, restarts at slot 0
    en = 1'b1;
    step(100);
    s_valid = 1'b1; s_pos = {8'd3, 8'd2, 8'd1, 8'd0};
    step(1);
    s_valid = 1'b0;
    chk("mid_pend", s_ready, 0);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("mid_ready", s_ready, 1);
    chk("mid_pulse", pulse_out, 0);
    chk("b_err_clr", b_err, 0);
    obs_a(256, 0, 0);
    chk("mid_pulses", a_cnt[0] + a_cnt[1] + a_cnt[2] + a_cnt[3], 0);
    chk("mid_sync_at", fs_first, SYNC ? 1 : 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
